hazard_stall_ctrl: RTL and testbench

- Stall scheduler for the five-stage pipeline.
- Keeps a shadow copy of the destination register and result-ready countdown (Tnew) for the instructions in E and M, plus the busy countdown of the multiply/divide unit.
- From these it decides each cycle whether the D-stage instruction may advance.
- It drives the fetch unit's `stall`, the D-register hold and the E-register flush (bubble insert).

---
 rtl/hazard_stall_ctrl.sv | 115 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: stall scheduler for the five-stage pipeline.
// It keeps shadow copies of the destination register and its result-ready
// countdown (Tnew) for the instructions in E and M, and the busy countdown
// of the multiply/divide unit. From these it decides each cycle whether the
// D-stage instruction may advance.
// Optional feature: define HAZARD_STALL_STAT_EN to compile in the 32-bit
// stall statistics counter; without it, stall_cnt is tied to zero.
module hazard_stall_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,   // busy cycles after mult/multu enters E (<= 15)
   parameter int unsigned DIV_CYCLES  = 10   // busy cycles after div/divu enters E (<= 15)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  rs_d,
   input  logic [4:0]  rt_d,
   input  logic        rs_use_d,
   input  logic        rt_use_d,
   input  logic [1:0]  tuse_rs_d,
   input  logic [1:0]  tuse_rt_d,
   input  logic [4:0]  dst_d,
   input  logic [1:0]  tnew_d,
   input  logic        md_start_d,
   input  logic        md_div_d,
   input  logic        md_use_d,
   output logic        stall,
   output logic        d_hold,
   output logic        e_flush,
   output logic        md_busy,
   output logic [31:0] stall_cnt
);

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

   logic [4:0] dst_e_q, dst_e_d;
   logic [1:0] tnew_e_q, tnew_e_d;
   logic [4:0] dst_m_q, dst_m_d;
   logic [1:0] tnew_m_q, tnew_m_d;
   logic [3:0] md_cnt_q, md_cnt_d;

   logic hz_rs, hz_rt, hz_md;

   // Hazard detection: a register source conflicts when a younger-stage
   // producer will not have its result ready by the time the source is used.
   // Register 0 is excluded on the source side, so a zero dst never matches.
   always_comb begin
      hz_rs = rs_use_d && (rs_d != 5'd0) &&
              (((rs_d == dst_e_q) && (tnew_e_q > tuse_rs_d)) ||
               ((rs_d == dst_m_q) && (tnew_m_q > tuse_rs_d)));
      hz_rt = rt_use_d && (rt_d != 5'd0) &&
              (((rt_d == dst_e_q) && (tnew_e_q > tuse_rt_d)) ||
               ((rt_d == dst_m_q) && (tnew_m_q > tuse_rt_d)));
      hz_md = md_use_d && md_busy;
      stall = hz_rs | hz_rt | hz_md;
   end

   assign md_busy = (md_cnt_q != 4'd0);
   assign d_hold  = stall;
   assign e_flush = stall;

   // Next-state for the shadows and MD counter. M always advances so that a
   // bubble inserted into E drains the hazard; the MD counter only loads
   // when the starting instruction actually leaves D.
   always_comb begin
      dst_m_d  = dst_e_q;
      tnew_m_d = (tnew_e_q == 2'd0) ? 2'd0 : tnew_e_q - 2'd1;
      if (stall) begin
         dst_e_d  = 5'd0;
         tnew_e_d = 2'd0;
      end else begin
         dst_e_d  = dst_d;
         tnew_e_d = tnew_d;
      end
      if (md_start_d && !stall)
         md_cnt_d = md_div_d ? DIV_LOAD : MULT_LOAD;
      else if (md_cnt_q != 4'd0)
         md_cnt_d = md_cnt_q - 4'd1;
      else
         md_cnt_d = 4'd0;
   end

   // State register for shadows and MD counter, synchronously cleared.
   always_ff @(posedge clk) begin
      if (reset) begin
         dst_e_q  <= 5'd0;
         tnew_e_q <= 2'd0;
         dst_m_q  <= 5'd0;
         tnew_m_q <= 2'd0;
         md_cnt_q <= 4'd0;
      end else begin
         dst_e_q  <= dst_e_d;
         tnew_e_q <= tnew_e_d;
         dst_m_q  <= dst_m_d;
         tnew_m_q <= tnew_m_d;
         md_cnt_q <= md_cnt_d;
      end
   end

`ifdef HAZARD_STALL_STAT_EN
   logic [31:0] stall_cnt_q;

   // Count every edge on which the D instruction was held; wraps naturally.
   always_ff @(posedge clk) begin
      if (reset)
         stall_cnt_q <= 32'd0;
      else if (stall)
         stall_cnt_q <= stall_cnt_q + 32'd1;
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: each step drives the D-stage inputs
// just after a rising edge, pushes the expected outputs to a scoreboard and
// pops/compares them on the falling edge of the same cycle.
module tb_hazard_stall_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rs_d, rt_d, dst_d;
   logic        rs_use_d, rt_use_d;
   logic [1:0]  tuse_rs_d, tuse_rt_d, tnew_d;
   logic        md_start_d, md_div_d, md_use_d;
   logic        stall, d_hold, e_flush, md_busy;
   logic [31:0] stall_cnt;

   int tests = 0;
   int fails = 0;
   logic [31:0] exp_cnt = 32'd0;

   typedef struct {
      string       tag;
      logic        stall;
      logic        busy;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset),
      .rs_d(rs_d), .rt_d(rt_d), .rs_use_d(rs_use_d), .rt_use_d(rt_use_d),
      .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d),
      .dst_d(dst_d), .tnew_d(tnew_d),
      .md_start_d(md_start_d), .md_div_d(md_div_d), .md_use_d(md_use_d),
      .stall(stall), .d_hold(d_hold), .e_flush(e_flush),
      .md_busy(md_busy), .stall_cnt(stall_cnt)
   );

   task automatic drv(input logic [4:0] rs, input logic rsu, input logic [1:0] trs,
                      input logic [4:0] rt, input logic rtu, input logic [1:0] trt,
                      input logic [4:0] dst, input logic [1:0] tn,
                      input logic mds, input logic mdd, input logic mdu);
      rs_d = rs; rs_use_d = rsu; tuse_rs_d = trs;
      rt_d = rt; rt_use_d = rtu; tuse_rt_d = trt;
      dst_d = dst; tnew_d = tn;
      md_start_d = mds; md_div_d = mdd; md_use_d = mdu;
   endtask

   task automatic idle();
      drv(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic chk(input string tag, input string what, input logic [31:0] obs,
                      input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, expv);
      end
   endtask

   // One cycle with the currently driven inputs.
   task automatic step(input string tag, input logic es, input logic eb);
      exp_t e;
      exp_t got;
      e.tag = tag; e.stall = es; e.busy = eb;
`ifdef HAZARD_STALL_STAT_EN
      e.cnt = exp_cnt;
`else
      e.cnt = 32'd0;
`endif
      sb_q.push_back(e);
      @(negedge clk);
      got = sb_q.pop_front();
      chk(got.tag, "stall",     {31'd0, stall},   {31'd0, got.stall});
      chk(got.tag, "d_hold",    {31'd0, d_hold},  {31'd0, got.stall});
      chk(got.tag, "e_flush",   {31'd0, e_flush}, {31'd0, got.stall});
      chk(got.tag, "md_busy",   {31'd0, md_busy}, {31'd0, got.busy});
      chk(got.tag, "stall_cnt", stall_cnt,        got.cnt);
      if (reset)      exp_cnt = 32'd0;
      else if (es)    exp_cnt = exp_cnt + 32'd1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state
      step("reset_idle", 1'b0, 1'b0);

      // Load-use: lw $8; addu reads $8 in E
      drv(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0);
      step("lu_lw", 1'b0, 1'b0);
      drv(5'd8, 1'b1, 2'd1, 5'd0, 1'b0, 2'd0, 5'd9, 2'd1, 1'b0, 1'b0, 1'b0);
      step("lu_stall", 1'b1, 1'b0);
      step("lu_adv", 1'b0, 1'b0);
      idle();
      step("lu_idle", 1'b0, 1'b0);
      step("lu_idle2", 1'b0, 1'b0);

      // Branch after load: two stall cycles
      drv(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0);
      step("bl_lw", 1'b0, 1'b0);
      drv(5'd8, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      step("bl_stall1", 1'b1, 1'b0);
      step("bl_stall2", 1'b1, 1'b0);
      step("bl_adv", 1'b0, 1'b0);

      // Branch after ALU op: one stall cycle
      drv(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd8, 2'd1, 1'b0, 1'b0, 1'b0);
      step("ba_addu", 1'b0, 1'b0);
      drv(5'd8, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      step("ba_stall", 1'b1, 1'b0);
      step("ba_adv", 1'b0, 1'b0);

      // rt-side load-use
      drv(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd10, 2'd2, 1'b0, 1'b0, 1'b0);
      step("rt_lw", 1'b0, 1'b0);
      drv(5'd3, 1'b1, 2'd1, 5'd10, 1'b1, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      step("rt_stall", 1'b1, 1'b0);
      step("rt_adv", 1'b0, 1'b0);

      // Hazard against the M-stage shadow: lw $8; nop; beq $8
      drv(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0);
      step("m_lw", 1'b0, 1'b0);
      idle();
      step("m_nop", 1'b0, 1'b0);
      drv(5'd8, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      step("m_stall", 1'b1, 1'b0);
      step("m_adv", 1'b0, 1'b0);

      // Unused source never stalls
      drv(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0);
      step("nouse_lw", 1'b0, 1'b0);
      drv(5'd8, 1'b0, 2'd0, 5'd8, 1'b0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      step("nouse", 1'b0, 1'b0);

      // Register 0: dst_e = 0 with tnew 2, rs = 0 read
      drv(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
      step("r0_prod", 1'b0, 1'b0);
      drv(5'd0, 1'b1, 2'd0, 5'd0, 1'b1, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      step("r0_read", 1'b0, 1'b0);

      // div then mflo: 10 busy / stall cycles
      drv(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
      step("div_start", 1'b0, 1'b0);
      drv(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd12, 2'd1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) step($sformatf("div_busy%0d", i), 1'b1, 1'b1);
      step("div_mflo_adv", 1'b0, 1'b0);
      idle();
      step("div_idle", 1'b0, 1'b0);

      // mult then mfhi: 5 busy / stall cycles
      drv(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1);
      step("mult_start", 1'b0, 1'b0);
      drv(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd13, 2'd1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step($sformatf("mult_busy%0d", i), 1'b1, 1'b1);
      step("mult_mfhi_adv", 1'b0, 1'b0);
      idle();
      step("mult_idle", 1'b0, 1'b0);

      // Busy alone does not stall an instruction that does not use MD
      drv(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1);
      step("mult2_start", 1'b0, 1'b0);
      idle();
      for (int i = 0; i < 5; i++) step($sformatf("mult2_nouse%0d", i), 1'b0, 1'b1);
      step("mult2_done", 1'b0, 1'b0);

      // Reset during the 3rd busy cycle of a div with mflo waiting
      drv(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
      step("rst_div_start", 1'b0, 1'b0);
      drv(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd12, 2'd1, 1'b0, 1'b0, 1'b1);
      step("rst_busy1", 1'b1, 1'b1);
      step("rst_busy2", 1'b1, 1'b1);
      reset = 1'b1;
      step("rst_busy3", 1'b1, 1'b1);
      reset = 1'b0;
      step("rst_after", 1'b0, 1'b0);
      idle();
      step("rst_idle", 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
